// File: rtl/nfp_fix_to_single_pipe.sv
// nfp_fix_to_single_pipe
// Three-stage converter from a signed fixed-point sample to an IEEE-754
// single-precision word, rounded to nearest even.
//
// Handshake: a sample transfers on a rising edge where in_valid & in_ready.
// A result transfers on a rising edge where out_valid & out_ready. The whole
// pipeline advances together when adv = ~out_valid | out_ready, and in_ready
// is exactly adv. While the output is stalled, every stage holds its contents.
// Bubbles travel through the pipeline as empty slots and are not squeezed out.
module nfp_fix_to_single_pipe #(
  parameter int IN_WIDTH = 16,
  parameter int FRAC_LEN = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [31:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  // Width of the left-aligned fraction. It always covers 23 mantissa bits,
  // a guard bit and at least one sticky bit.
  localparam int FW = (IN_WIDTH - 1 > 25) ? IN_WIDTH - 1 : 25;

  // Leading-zero count. An all-zero input returns IN_WIDTH; the zero flag
  // makes that case irrelevant downstream.
  function automatic logic [5:0] lzc_f(input logic [IN_WIDTH-1:0] v);
    logic [5:0] n;
    logic       seen;
    n    = 6'd0;
    seen = 1'b0;
    for (int i = IN_WIDTH - 1; i >= 0; i--) begin
      if (!seen) begin
        if (v[i]) seen = 1'b1;
        else      n    = n + 6'd1;
      end
    end
    return n;
  endfunction

  logic                adv;

  // Stage 1: sign, magnitude, zero flag
  logic                v1_q, sign1_q, zero1_q;
  logic                sign1_d, zero1_d;
  logic [IN_WIDTH-1:0] mag1_q, mag1_d;

  // Stage 2: normalized fraction (leading one dropped) and unbiased exponent
  logic                v2_q, sign2_q, zero2_q;
  logic                zero2_d;
  logic [IN_WIDTH-2:0] norm2_q, norm2_d;
  logic [7:0]          exp2_q, exp2_d;
  logic [5:0]          lzc2;
  logic [IN_WIDTH-1:0] shifted2;

  // Stage 3: packed result
  logic                v3_q;
  logic [31:0]         out_q, out_d;
  logic [FW-1:0]       fr_ext3;
  logic [22:0]         mant3;
  logic                guard3, sticky3, round3;
  logic [23:0]         msum3;
  logic [7:0]          bexp3;

  assign adv       = ~v3_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_data  = out_q;

  // Capture: the magnitude keeps the full input width so the most negative
  // sample converts without overflow.
  always_comb begin
    sign1_d = in_data[IN_WIDTH-1];
    mag1_d  = sign1_d ? (~in_data + IN_WIDTH'(1)) : in_data;
    zero1_d = (in_data == '0);
  end

  // Normalize: shift the leading one to the MSB and derive the exponent.
  // A magnitude that fails to reach a leading one is also treated as zero.
  always_comb begin
    lzc2     = lzc_f(mag1_q);
    shifted2 = mag1_q << lzc2;
    norm2_d  = shifted2[IN_WIDTH-2:0];
    exp2_d   = 8'(IN_WIDTH - 1 - FRAC_LEN) - {2'b00, lzc2};
    zero2_d  = zero1_q | ~shifted2[IN_WIDTH-1];
  end

  // Round and pack: nearest-even on guard/sticky, carry bumps the exponent.
  // Narrow inputs fit the mantissa exactly, so rounding is tied off.
  always_comb begin
    fr_ext3 = FW'(norm2_q) << (FW - (IN_WIDTH - 1));
    mant3   = fr_ext3[FW-1 -: 23];
    guard3  = fr_ext3[FW-24];
    sticky3 = |fr_ext3[FW-25:0];
    round3  = (IN_WIDTH > 24) ? (guard3 & (sticky3 | mant3[0])) : 1'b0;
    msum3   = {1'b0, mant3} + {23'd0, round3};
    bexp3   = 8'd127 + exp2_q + {7'd0, msum3[23]};
    out_d   = zero2_q ? 32'd0 : {sign2_q, bexp3, msum3[22:0]};
  end

  // Valid bits shift together on every advance; reset empties the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // Stage 1 payload, loaded only for a real sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign1_q <= 1'b0;
      zero1_q <= 1'b0;
      mag1_q  <= '0;
    end else if (adv && in_valid) begin
      sign1_q <= sign1_d;
      zero1_q <= zero1_d;
      mag1_q  <= mag1_d;
    end
  end

  // Stage 2 payload, loaded only when stage 1 holds a sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign2_q <= 1'b0;
      zero2_q <= 1'b0;
      norm2_q <= '0;
      exp2_q  <= 8'd0;
    end else if (adv && v1_q) begin
      sign2_q <= sign1_q;
      zero2_q <= zero2_d;
      norm2_q <= norm2_d;
      exp2_q  <= exp2_d;
    end
  end

  // Output word; cleared by reset so out_data reads zero immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= 32'd0;
    end else if (adv && v2_q) begin
      out_q <= out_d;
    end
  end

endmodule
